// File: rtl/key_color_pkg.sv
// Shared definitions for the key-driven colour selector: palette index width,
// MODE encodings and the 8-entry palette lookup.
package key_color_pkg;

    localparam int IDX_W       = 3;
    localparam int MODE_DIRECT = 0;
    localparam int MODE_STEP   = 1;

    typedef logic [IDX_W-1:0] idx_t;

    typedef enum logic [IDX_W-1:0] {
        C_WHITE   = 3'd0,
        C_BLUE    = 3'd1,
        C_GREEN   = 3'd2,
        C_RED     = 3'd3,
        C_YELLOW  = 3'd4,
        C_CYAN    = 3'd5,
        C_MAGENTA = 3'd6,
        C_BLACK   = 3'd7
    } color_e;

    // Returns {r, g, b} on/off flags; the top widens each flag to a full channel.
    function automatic logic [2:0] palette_rgb(input idx_t idx);
        logic [2:0] rgb;
        rgb = 3'b000;
        case (color_e'(idx))
            C_WHITE:   rgb = 3'b111;
            C_BLUE:    rgb = 3'b001;
            C_GREEN:   rgb = 3'b010;
            C_RED:     rgb = 3'b100;
            C_YELLOW:  rgb = 3'b110;
            C_CYAN:    rgb = 3'b011;
            C_MAGENTA: rgb = 3'b101;
            default:   rgb = 3'b000;
        endcase
        return rgb;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// One key: 2-flop synchroniser, saturating debounce counter and a one-cycle
// pulse on each debounced press (1->0); releases produce no pulse.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_p0;
    logic             sync_p1;
    logic             level_p2;
    logic             level_d;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0  <= 1'b1;
            sync_p1  <= 1'b1;
            level_p2 <= 1'b1;
            level_d  <= 1'b1;
            cnt      <= '0;
        end else begin
            sync_p0 <= key_n;
            sync_p1 <= sync_p0;
            level_d <= level_p2;
            // Any cycle agreeing with the accepted level restarts the count;
            // the >= compare keeps the counter from ever wrapping.
            if (sync_p1 == level_p2) begin
                cnt <= '0;
            end else if (cnt >= CNT_LAST) begin
                level_p2 <= sync_p1;
                cnt      <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign press = level_d & ~level_p2;

endmodule

// File: rtl/key_color_ctrl.sv
// Key-driven palette colour selector for a VGA pipeline. Optional registered
// blanking on video_on is enabled by defining KEY_COLOR_CTRL_BLANK_EN.
module key_color_ctrl
    import key_color_pkg::*;
#(
    parameter int NUM_KEYS        = 4,
    parameter int COLOR_W         = 4,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int MODE            = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_KEYS-1:0] key_n,
    input  logic               video_on,
    output logic [COLOR_W-1:0] red,
    output logic [COLOR_W-1:0] green,
    output logic [COLOR_W-1:0] blue,
    output logic [IDX_W-1:0]   color_idx
);

    logic [NUM_KEYS-1:0] press;
    idx_t                idx_next;
    logic [2:0]          rgb_flags;
    logic                show;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_key_debounce (
            .clk  (clk),
            .rst_n(rst_n),
            .key_n(key_n[i]),
            .press(press[i])
        );
    end

    always_comb begin
        idx_next = color_idx;
        if (MODE == MODE_DIRECT) begin
            // Scan high to low so the lowest pressed key wins.
            for (int i = NUM_KEYS - 1; i >= 0; i--) begin
                if (press[i]) idx_next = idx_t'(i + 1);
            end
        end else begin
            if (press[0] && !press[1]) begin
                idx_next = color_idx + 1'b1;
            end else if (press[1] && !press[0]) begin
                idx_next = color_idx - 1'b1;
            end
        end
    end

`ifdef KEY_COLOR_CTRL_BLANK_EN
    assign show = video_on;
`else
    logic unused_video_on;
    assign unused_video_on = video_on;
    assign show = 1'b1;
`endif

    assign rgb_flags = palette_rgb(color_idx);

    // Colour is registered from the already-registered index: one cycle behind it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            color_idx <= '0;
            red       <= '1;
            green     <= '1;
            blue      <= '1;
        end else begin
            color_idx <= idx_next;
            red       <= {COLOR_W{show & rgb_flags[2]}};
            green     <= {COLOR_W{show & rgb_flags[1]}};
            blue      <= {COLOR_W{show & rgb_flags[0]}};
        end
    end

endmodule

// File: tb/tb_key_color_ctrl.sv
// Directed bench for key_color_ctrl: one MODE 0 and one MODE 1 instance with
// DEBOUNCE_CYCLES = 4, COLOR_W = 4.
module tb_key_color_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] key0_n;
    logic [3:0] key1_n;
    logic       video_on;
    logic [3:0] red0, green0, blue0;
    logic [3:0] red1, green1, blue1;
    logic [2:0] idx0, idx1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    key_color_ctrl #(
        .NUM_KEYS(4), .COLOR_W(4), .DEBOUNCE_CYCLES(4), .MODE(0)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .key_n(key0_n), .video_on(video_on),
        .red(red0), .green(green0), .blue(blue0), .color_idx(idx0)
    );

    key_color_ctrl #(
        .NUM_KEYS(4), .COLOR_W(4), .DEBOUNCE_CYCLES(4), .MODE(1)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .key_n(key1_n), .video_on(video_on),
        .red(red1), .green(green1), .blue(blue1), .color_idx(idx1)
    );

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press1(input logic [3:0] mask);
        key1_n = ~mask;
        step(8);
        key1_n = 4'hf;
        step(8);
    endtask

    initial begin
        logic idle_ok;
        rst_n    = 1'b0;
        key0_n   = 4'hf;
        key1_n   = 4'hf;
        video_on = 1'b1;
        step(2);
        check("reset_idx", {9'd0, idx0}, 12'h000);
        check("reset_rgb", {red0, green0, blue0}, 12'hfff);
        rst_n = 1'b1;

        idle_ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (idx0 !== 3'd0 || {red0, green0, blue0} !== 12'hfff) idle_ok = 1'b0;
        end
        check("idle_20", {11'd0, idle_ok}, 12'h001);

        // MODE 0: key 2 held 10 cycles -> red after 2+4+2 edges
        key0_n[2] = 1'b0;
        step(6);
        check("k2_idx_early", {9'd0, idx0}, 12'h000);
        step(1);
        check("k2_idx", {9'd0, idx0}, 12'h003);
        check("k2_rgb_lag", {red0, green0, blue0}, 12'hfff);
        step(1);
        check("k2_rgb", {red0, green0, blue0}, 12'hf00);
        step(2);
        key0_n[2] = 1'b1;
        step(10);
        check("k2_sticky_idx", {9'd0, idx0}, 12'h003);
        check("k2_sticky_rgb", {red0, green0, blue0}, 12'hf00);

        // Bouncing key 1 never settles, then a clean hold is accepted
        for (int i = 0; i < 5; i++) begin
            key0_n[1] = 1'b0;
            step(2);
            key0_n[1] = 1'b1;
            step(2);
        end
        check("bounce_idx", {9'd0, idx0}, 12'h003);
        key0_n[1] = 1'b0;
        step(8);
        check("k1_idx", {9'd0, idx0}, 12'h002);
        check("k1_rgb", {red0, green0, blue0}, 12'h0f0);
        key0_n[1] = 1'b1;
        step(8);

        // Simultaneous keys 0 and 3: lowest index wins
        key0_n = 4'b0110;
        step(8);
        check("prio_idx", {9'd0, idx0}, 12'h001);
        check("prio_rgb", {red0, green0, blue0}, 12'h00f);
        key0_n = 4'hf;
        step(8);

        // Blanking on video_on
        video_on = 1'b0;
        step(1);
`ifdef KEY_COLOR_CTRL_BLANK_EN
        check("blank_rgb", {red0, green0, blue0}, 12'h000);
`else
        check("noblank_rgb", {red0, green0, blue0}, 12'h00f);
`endif
        check("blank_idx", {9'd0, idx0}, 12'h001);
        video_on = 1'b1;
        step(1);
        check("unblank_rgb", {red0, green0, blue0}, 12'h00f);

        // MODE 1: decrement wraps 0 -> 7, increments wrap 7 -> 0
        press1(4'b0010);
        check("m1_dec_idx", {9'd0, idx1}, 12'h007);
        check("m1_dec_rgb", {red1, green1, blue1}, 12'h000);
        press1(4'b0001);
        check("m1_inc_wrap", {9'd0, idx1}, 12'h000);
        check("m1_inc_rgb", {red1, green1, blue1}, 12'hfff);
        for (int i = 0; i < 7; i++) press1(4'b0001);
        check("m1_eight_inc", {9'd0, idx1}, 12'h007);
        press1(4'b0011);
        check("m1_both", {9'd0, idx1}, 12'h007);
        press1(4'b0100);
        check("m1_key2_ignored", {9'd0, idx1}, 12'h007);

        // Reset mid-debounce with key 0 held
        key0_n[0] = 1'b0;
        step(3);
        rst_n = 1'b0;
        #1;
        check("rst_async_idx", {9'd0, idx0}, 12'h000);
        check("rst_async_rgb", {red0, green0, blue0}, 12'hfff);
        step(2);
        rst_n = 1'b1;
        step(6);
        check("rst_held_early", {9'd0, idx0}, 12'h000);
        step(1);
        check("rst_held_idx", {9'd0, idx0}, 12'h001);
        step(1);
        check("rst_held_rgb", {red0, green0, blue0}, 12'h00f);
        key0_n = 4'hf;
        step(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/key_color_ctrl.md
KEY_COLOR_CTRL -- requirements
Module: key_color_ctrl

Interface
REQ-001 SHALL have parameter NUM_KEYS, default 4: number of active-low keys, legal 2..7.
REQ-002 SHALL have parameter COLOR_W, default 4: bits per colour channel.
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 250000: consecutive stable cycles to accept a key level, legal 2..2^20.
REQ-004 SHALL have parameter MODE, default 0: 0 = direct select, 1 = step through palette.
REQ-005 SHALL have port clk, input, 1: sole clock.
REQ-006 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port key_n, input, NUM_KEYS: raw asynchronous keys, 0 = pressed.
REQ-008 SHALL have port video_on, input, 1: display-active window from the VGA timing block.
REQ-009 SHALL have ports red, green, blue, output, COLOR_W each: registered colour.
REQ-010 SHALL have port color_idx, output, 3: registered current palette index.

Function
REQ-011 SHALL pass each key_n bit through a 2-flop synchroniser before any other logic.
REQ-012 SHALL debounce each key independently: debounced level changes only after the synchronised level differs from it for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts that key's counter at 0.
REQ-013 SHALL generate a one-cycle press pulse per key on each debounced 1->0 transition; release generates nothing.
REQ-014 SHALL keep the selected colour after release (sticky); no key held SHALL NOT revert to a default.
REQ-015 SHALL use an 8-entry palette: 0 white, 1 blue, 2 green, 3 red, 4 yellow, 5 cyan, 6 magenta, 7 black; each channel is all-ones or all-zeros of COLOR_W.
REQ-016 MODE 0: press on key i SHALL load color_idx = i+1; simultaneous presses SHALL resolve to the lowest key index.
REQ-017 MODE 1: press on key 0 SHALL increment color_idx mod 8 (7->0); press on key 1 SHALL decrement mod 8 (0->7); keys 2.. SHALL be ignored; simultaneous key 0 and key 1 presses SHALL leave color_idx unchanged.
REQ-018 color_idx SHALL update on the clock edge after the press pulse; red/green/blue SHALL update one cycle after color_idx (total latency from debounced edge: 2 cycles).
REQ-019 Debounce counters SHALL saturate and never wrap; width = ceil(log2(DEBOUNCE_CYCLES+1)).

Reset
REQ-020 Asserting rst_n low SHALL immediately force color_idx = 0, red/green/blue = all-ones, debounced levels = 1 (released), counters = 0, synchroniser flops = 1.
REQ-021 A key held through reset deassertion SHALL NOT generate a press until it is released and pressed again, or until it is debounced from the released state (counter runs from 0).

Configuration
REQ-022 Macro KEY_COLOR_CTRL_BLANK_EN defined: red/green/blue SHALL be 0 in any cycle following one where video_on = 0 (registered blanking); color_idx SHALL be unaffected.
REQ-023 Macro KEY_COLOR_CTRL_BLANK_EN undefined: video_on SHALL be ignored and outputs SHALL always show the palette colour.

Structure
REQ-024 Palette constants, index width (3) and MODE encodings SHALL live in shared package key_color_pkg.
REQ-025 Synchroniser plus debounce plus edge detect for one key SHALL be sub-module key_debounce, instantiated NUM_KEYS times via generate.

Verification (DEBOUNCE_CYCLES = 4, COLOR_W = 4)
REQ-026 Reset then idle 20 cycles -> color_idx = 0, rgb = f/f/f throughout.
REQ-027 MODE 0, key_n[2] low for 10 cycles then high -> color_idx = 3, rgb = f/0/0 exactly 2+4+2 cycles after press, held after release.
REQ-028 MODE 0, key_n[1] toggled every 2 cycles for 20 cycles -> no change in color_idx; then held low 8 cycles -> color_idx = 2.
REQ-029 MODE 1 from idx 0, one key 1 press -> idx 7, rgb 0/0/0; eight key 0 presses -> idx 7 again; key 0 and key 1 pressed in same cycle -> idx unchanged.
REQ-030 BLANK_EN defined, idx 1, video_on = 0 -> rgb = 0/0/0 next cycle, color_idx = 1; video_on = 1 -> rgb = 0/0/f next cycle.
REQ-031 rst_n pulsed low mid-debounce with key_n[0] held low -> outputs white immediately; after release of reset, press accepted only after 2 + 4 stable cycles.
